// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: UART receiver that turns each good byte into one register write.
// byte[7:5] -> address, byte[4:0] -> data, committed by a one-cycle write_strobe.
// Optional feature macro: UART_RX_PARITY_EN (8E1 frames with an even-parity check).
// Without the macro the frame format is 8N1 and no parity logic is built.

module uart_cmd_rx #(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       write_strobe,
  output logic [2:0] address,
  output logic [4:0] data,
  output logic       frame_error,
  output logic       rx_busy
);

  // Counter compare points: last cycle of a bit, and mid-start-bit.
  localparam logic [11:0] CntLast = 12'(CLKS_PER_BIT - 1);
  localparam logic [11:0] CntHalf = 12'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStart    = 3'd1,
    StData     = 3'd2,
`ifdef UART_RX_PARITY_EN
    StParity   = 3'd3,
`endif
    StStop     = 3'd4,
    StWaitHigh = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;

  logic        rx_meta_q;
  logic        rx_s_q;

  logic        write_strobe_q, write_strobe_d;
  logic        frame_error_q, frame_error_d;
  logic [2:0]  address_q, address_d;
  logic [4:0]  data_q, data_d;

  logic        cnt_last;
  logic        stop_sample;
  logic        parity_ok;
  logic        frame_good;

`ifdef UART_RX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  // Two-flop synchronizer; idles at 1 so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign cnt_last    = (cnt_q == CntLast);
  assign stop_sample = (state_q == StStop) && cnt_last;

`ifdef UART_RX_PARITY_EN
  // Even parity: data bits XOR parity bit must be zero.
  assign parity_ok = ~(^{shift_q, parity_q});
`else
  assign parity_ok = 1'b1;
`endif

  assign frame_good = rx_s_q && parity_ok;

  // State register and receive datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
`ifdef UART_RX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Next-state: bit timing, sampling and frame sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 12'd1;
    idx_d   = idx_q;
    shift_d = shift_q;
`ifdef UART_RX_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_s_q) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d = '0;
          idx_d = '0;
          // A start bit that is high again at mid-bit was only a glitch.
          state_d = rx_s_q ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_last) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_q;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (cnt_last) begin
          cnt_d    = '0;
          parity_d = rx_s_q;
          state_d  = StStop;
        end
      end
`endif
      StStop: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = frame_good ? StIdle : StWaitHigh;
        end
      end
      StWaitHigh: begin
        // Hold off until the line returns high so a break is not read as start bits.
        cnt_d = '0;
        if (rx_s_q) begin
          state_d = StIdle;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Registered outputs of the write bus and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_strobe_q <= 1'b0;
      frame_error_q  <= 1'b0;
      address_q      <= '0;
      data_q         <= '0;
    end else begin
      write_strobe_q <= write_strobe_d;
      frame_error_q  <= frame_error_d;
      address_q      <= address_d;
      data_q         <= data_d;
    end
  end

  // Output decode: stop sample either commits the byte or flags the frame.
  always_comb begin
    write_strobe_d = stop_sample && frame_good;
    frame_error_d  = stop_sample && !frame_good;
    address_d      = address_q;
    data_d         = data_q;
    if (write_strobe_d) begin
      address_d = shift_q[7:5];
      data_d    = shift_q[4:0];
    end
  end

  assign write_strobe = write_strobe_q;
  assign frame_error  = frame_error_q;
  assign address      = address_q;
  assign data         = data_q;
  assign rx_busy      = (state_q != StIdle);

`ifndef SYNTHESIS
  a_excl: assert property (@(posedge clk) disable iff (rst)
    !(write_strobe_q && frame_error_q));
  a_strobe_one: assert property (@(posedge clk) disable iff (rst)
    write_strobe_q |=> !write_strobe_q);
  a_ferr_one: assert property (@(posedge clk) disable iff (rst)
    frame_error_q |=> !frame_error_q);
`endif

endmodule
